// File: rtl/seq_burst_arbiter.sv
// seq_burst_arbiter
//   Two-requester round-robin burst arbiter. Both requesters share one
//   custom-order sequence generator. Each granted burst delivers 'len' steps
//   of that sequence. An IDLE -> RUN -> GAP FSM sequences the bursts, and all
//   outputs are registered.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   req    in   [1:0] level burst request per requester, held until granted
//   len0   in   [LEN_W-1:0] burst length of requester 0, sampled at grant
//   len1   in   [LEN_W-1:0] burst length of requester 1, sampled at grant
//   gnt    out  [1:0] one-hot grant, high for the whole burst
//   count  out  [3:0] current value of the shared sequence generator
//   valid  out  count is a delivered step for the granted requester
//   last   out  final step of the current burst (only with valid)
//   done   out  [1:0] one-cycle pulse to the owner after a completed burst
//   abort  out  one-cycle pulse after a burst cut short by request withdrawal
module seq_burst_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [3:0]       count,
  output logic             valid,
  output logic             last,
  output logic [1:0]       done,
  output logic             abort
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t           state;
  logic             ptr;        // requester favoured when both request
  logic             owner;      // requester holding the current burst
  logic [LEN_W-1:0] remaining;  // steps left including the one on display

  // Successor of the shared sequence; unlisted values recover to 0000.
  function automatic logic [3:0] seq_next(input logic [3:0] v);
    case (v)
      4'b0000: seq_next = 4'b1001;
      4'b1001: seq_next = 4'b1010;
      4'b1010: seq_next = 4'b1100;
      4'b1100: seq_next = 4'b0111;
      4'b0111: seq_next = 4'b1101;
      4'b1101: seq_next = 4'b0100;
      4'b0100: seq_next = 4'b0101;
      4'b0101: seq_next = 4'b0110;
      default: seq_next = 4'b0000;
    endcase
  endfunction

  // Arbitration choice: a lone requester always wins; otherwise the pointer decides.
  logic             pick;
  logic [LEN_W-1:0] pick_len;

  always_comb begin
    pick = ptr;
    if (req == 2'b01)
      pick = 1'b0;
    else if (req == 2'b10)
      pick = 1'b1;
    pick_len = pick ? len1 : len0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      remaining <= '0;
      count     <= 4'b0000;
      gnt       <= 2'b00;
      valid     <= 1'b0;
      last      <= 1'b0;
      done      <= 2'b00;
      abort     <= 1'b0;
    end else begin
      done  <= 2'b00;
      abort <= 1'b0;
      // The generator steps once per delivered (valid) cycle only.
      if (valid)
        count <= seq_next(count);
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= RUN;
            owner     <= pick;
            gnt       <= pick ? 2'b10 : 2'b01;
            valid     <= 1'b1;
            // A zero length still delivers one step.
            remaining <= (pick_len == '0) ? LEN_W'(1) : pick_len;
            last      <= (pick_len <= LEN_W'(1));
          end
        end
        RUN: begin
          if (!req[owner] || remaining == LEN_W'(1)) begin
            // Withdrawal wins over completion; the current step was still delivered.
            if (!req[owner])
              abort <= 1'b1;
            else
              done  <= owner ? 2'b10 : 2'b01;
            state     <= GAP;
            gnt       <= 2'b00;
            valid     <= 1'b0;
            last      <= 1'b0;
            remaining <= '0;
            ptr       <= ~owner;
          end else begin
            remaining <= remaining - LEN_W'(1);
            last      <= (remaining == LEN_W'(2));
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_burst_arbiter.sv
// Scoreboard bench for seq_burst_arbiter. Expected steps and end-of-burst
// events are queued when a round is issued. A monitor pops and compares
// them whenever the DUT shows valid, done or abort.
module tb_seq_burst_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'd0;
  logic [3:0] len1 = 4'd0;
  logic [1:0] gnt;
  logic [3:0] count;
  logic       valid;
  logic       last;
  logic [1:0] done;
  logic       abort;

  always #5 clk = ~clk;

  seq_burst_arbiter #(.LEN_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .count(count), .valid(valid), .last(last),
    .done(done), .abort(abort)
  );

  // kind: 0 = step, 1 = done, 2 = abort
  typedef struct {
    int         kind;
    int         owner;
    logic [3:0] cnt;
    logic       lst;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  bit  chk_en = 1'b0;

  // Reference model state: position in the 9-value cycle and the RR pointer.
  logic [3:0] seqv [9] = '{4'h0, 4'h9, 4'hA, 4'hC, 4'h7, 4'hD, 4'h4, 4'h5, 4'h6};
  int m_pos = 0;
  int m_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A burst of effective length n, withdrawn after step d (0 = never).
  task automatic push_burst(input int owner, input int n, input int d);
    ev_t e;
    int steps;
    steps = (d != 0) ? d : n;
    for (int s = 0; s < steps; s++) begin
      e.kind  = 0;
      e.owner = owner;
      e.cnt   = seqv[m_pos];
      e.lst   = (d == 0) && (s == steps - 1);
      sb.push_back(e);
      m_pos = (m_pos + 1) % 9;
    end
    e.kind  = (d != 0) ? 2 : 1;
    e.owner = owner;
    e.cnt   = 4'h0;
    e.lst   = 1'b0;
    sb.push_back(e);
    m_ptr = 1 - owner;
  endtask

  // Monitor
  initial begin
    ev_t e;
    bit pv, pl;
    int akind;
    pv = 0;
    pl = 0;
    forever begin
      @(negedge clk);
      if (reset || !chk_en) begin
        pv = 0;
        pl = 0;
      end else begin
        if (valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_step actual=%0h required=none", count);
          end else begin
            e = sb.pop_front();
            check("step_kind", 0, e.kind);
            check("step_gnt", gnt, 2'b01 << e.owner);
            check("step_count", count, e.cnt);
            check("step_last", last, e.lst);
          end
        end else begin
          check("idle_gnt", gnt, 2'b00);
          check("idle_last", last, 1'b0);
        end
        check("done_abort_excl", (done != 2'b00) && abort, 1'b0);
        if (pl)
          check("done_after_last", done != 2'b00, 1'b1);
        if (done != 2'b00 || abort) begin
          check("gap_follows_step", pv, 1'b1);
          akind = (done != 2'b00) ? 1 : 2;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_end actual=%0h required=none", {done, abort});
          end else begin
            e = sb.pop_front();
            check("end_kind", akind, e.kind);
            check("done_bits", done, (e.kind == 1) ? (2'b01 << e.owner) : 2'b00);
            check("abort_bit", abort, e.kind == 2);
          end
        end
        pv = valid;
        pl = valid && last;
      end
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    req    = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_outputs", {gnt, valid, last, done, abort, count}, 0);
    reset = 1'b0;
    sb.delete();
    m_pos  = 0;
    m_ptr  = 0;
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  // One round: mask of initial requests; 'late' raises the other bit on the
  // first step of a single-requester burst. d0/d1 = withdrawal step (0 = none).
  task automatic run_round(input logic [1:0] mask, input bit late,
                           input logic [3:0] l0, input logic [3:0] l1,
                           input int d0, input int d1);
    int nb, first, cyc, steps, left, fv, owner, dd, n0, n1;
    n0 = (l0 == 4'd0) ? 1 : int'(l0);
    n1 = (l1 == 4'd0) ? 1 : int'(l1);
    if (mask == 2'b11) begin
      first = m_ptr;
      nb    = 2;
    end else begin
      first = (mask == 2'b10) ? 1 : 0;
      nb    = late ? 2 : 1;
    end
    push_burst(first, first ? n1 : n0, first ? d1 : d0);
    if (nb == 2)
      push_burst(1 - first, first ? n0 : n1, first ? d0 : d1);
    req   = mask;
    len0  = l0;
    len1  = l1;
    cyc   = 0;
    steps = 0;
    left  = nb;
    fv    = -1;
    owner = first;
    while (left > 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        owner = gnt[1] ? 1 : 0;
        steps++;
        if (fv < 0)
          fv = cyc;
        if (late && left == nb && steps == 1)
          req[1 - owner] = 1'b1;
        dd = owner ? d1 : d0;
        if (dd != 0 && steps == dd)
          req[owner] = 1'b0;
      end
      if (done != 2'b00 || abort) begin
        req[owner] = 1'b0;
        left--;
        steps = 0;
      end
    end
    if (left > 0) begin
      total++;
      bad++;
      $display("FAIL round_timeout actual=%0d required=0 bursts left", left);
      do_reset();
    end else begin
      check("grant_latency", fv, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [1:0] mk;
    logic [3:0] a, b;
    bit lt;
    int e0, e1, x0, x1, st;

    do_reset();
    // Single burst, then sequence persistence into the next burst.
    run_round(2'b01, 1'b0, 4'd3, 4'd0, 0, 0);
    run_round(2'b01, 1'b0, 4'd2, 4'd0, 0, 0);
    // Both requesting: requester 0 first, then 1; the pointer then returns to 0.
    do_reset();
    run_round(2'b11, 1'b0, 4'd2, 4'd2, 0, 0);
    run_round(2'b11, 1'b0, 4'd1, 4'd3, 0, 0);
    // Ten steps with wrap-around.
    do_reset();
    run_round(2'b01, 1'b0, 4'd10, 4'd0, 0, 0);
    // Zero length gives one step; withdrawal after step 2 of 5.
    run_round(2'b10, 1'b0, 4'd0, 4'd0, 0, 0);
    run_round(2'b01, 1'b0, 4'd5, 4'd0, 2, 0);
    // Late request from the other side during RUN must wait, not preempt.
    run_round(2'b01, 1'b1, 4'd4, 4'd2, 0, 0);

    // Asynchronous reset during step 3 of a 6-step burst.
    do_reset();
    chk_en = 1'b0;
    req    = 2'b01;
    len0   = 4'd6;
    st     = 0;
    for (int i = 0; i < 20 && st < 3; i++) begin
      @(negedge clk);
      if (valid)
        st++;
    end
    check("mid_step3_count", count, 4'hA);
    #2 reset = 1'b1;
    #1 check("async_rst_outputs", {gnt, valid, last, done, abort, count}, 0);
    req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_pos  = 0;
    m_ptr  = 0;
    chk_en = 1'b1;
    @(negedge clk);
    run_round(2'b01, 1'b0, 4'd2, 4'd0, 0, 0);

    // Randomised rounds.
    for (int r = 0; r < 40; r++) begin
      mk = 2'($urandom_range(1, 3));
      lt = (mk != 2'b11) && ($urandom_range(0, 1) == 1);
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      e0 = (a == 4'd0) ? 1 : int'(a);
      e1 = (b == 4'd0) ? 1 : int'(b);
      x0 = (e0 >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, e0 - 1)) : 0;
      x1 = (e1 >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, e1 - 1)) : 0;
      run_round(mk, lt, a, b, x0, x1);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
